// File: rtl/sd_demux2.sv
// sd_demux2: srdy/drdy 1:2 demultiplexer. It collects two half-width tokens,
// upper half first, and emits one full-width token. p_data and p_srdy come
// straight from flops. c_drdy depends only on the phase, p_srdy and p_drdy,
// so an enmux/demux pair never forms a combinational loop through c_srdy.
module sd_demux2 #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [width/2-1:0] c_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
  output logic               partial
);

  localparam int HW = width / 2;

  typedef enum logic {
    S_UPPER = 1'b0,
    S_LOWER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_upper_q, hold_upper_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic            p_srdy_q, p_srdy_d;

  logic            c_xfer;
  logic            p_xfer;

  // An upper half can always be taken because it lands in hold_upper, not in
  // the output register. A lower half needs the output slot to be empty, or
  // to be draining on this same edge.
  assign c_drdy  = (state_q == S_UPPER) | ~p_srdy_q | p_drdy;
  assign c_xfer  = c_srdy & c_drdy;
  assign p_xfer  = p_srdy_q & p_drdy;

  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign partial = (state_q == S_LOWER);

  // Next-state logic: advance the phase and load halves on each input transfer.
  always_comb begin
    state_d      = state_q;
    hold_upper_d = hold_upper_q;
    p_data_d     = p_data_q;
    p_srdy_d     = p_srdy_q;

    // A drain with no new word behind it empties the slot.
    if (p_xfer) begin
      p_srdy_d = 1'b0;
    end

    if (c_xfer) begin
      if (state_q == S_UPPER) begin
        hold_upper_d = c_data;
        state_d      = S_LOWER;
      end else begin
        // A load wins over a same-edge drain, so p_srdy stays high.
        p_data_d = {hold_upper_q, c_data};
        p_srdy_d = 1'b1;
        state_d  = S_UPPER;
      end
    end
  end

  // Control flops. Reset drops any held half and any pending output token,
  // and it takes priority over a transfer on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_UPPER;
      p_srdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_srdy_q <= p_srdy_d;
    end
  end

  // Data flops have no reset. Their contents do not matter until the first load.
  always_ff @(posedge clk) begin
    hold_upper_q <= hold_upper_d;
    p_data_q     <= p_data_d;
  end

endmodule

// File: tb/tb_sd_demux2.sv
// Testbench for sd_demux2. It runs the directed scenarios first, then
// randomized traffic. Every cycle is checked against a token-level model:
// accepted halves are paired in arrival order, and finished words wait in a
// queue until they are drained.
module tb_sd_demux2;

  localparam int WIDTH = 8;
  localparam int HW    = WIDTH / 2;

  logic             clk;
  logic             reset;
  logic             c_srdy;
  logic             c_drdy;
  logic [HW-1:0]    c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [WIDTH-1:0] p_data;
  logic             partial;

  sd_demux2 #(.width(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .partial(partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int               halves_in;   // count of accepted halves since reset
  logic [HW-1:0]    upper_m;     // most recent upper half
  logic [WIDTH-1:0] exp_q[$];    // finished words not yet drained
  int               tokens_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    halves_in = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then let the
  // model advance through the clock edge.
  task automatic step(input logic cs, input logic [HW-1:0] cd, input logic pd, input logic rs);
    logic exp_cdrdy;
    logic exp_psrdy;
    logic px;
    logic cx;
    c_srdy = cs;
    c_data = cd;
    p_drdy = pd;
    reset  = rs;
    #1;
    exp_psrdy = (exp_q.size() != 0);
    // A half can be taken unless it is a lower half and the output slot is
    // full and not draining.
    exp_cdrdy = (halves_in % 2 == 0) || !exp_psrdy || pd;
    check("c_drdy",  {31'd0, c_drdy},  {31'd0, exp_cdrdy});
    check("p_srdy",  {31'd0, p_srdy},  {31'd0, exp_psrdy});
    check("partial", {31'd0, partial}, {31'd0, (halves_in % 2 == 1)});
    if (exp_psrdy) check("p_data", {24'd0, p_data}, {24'd0, exp_q[0]});
    px = exp_psrdy && pd;
    cx = cs && exp_cdrdy;
    if (px && !rs) begin
      $display("token out %h", exp_q[0]);
      tokens_out++;
    end
    if (rs) begin
      model_reset();
    end else begin
      if (px) void'(exp_q.pop_front());
      if (cx) begin
        if (halves_in % 2 == 0) upper_m = cd;
        else exp_q.push_back({upper_m, cd});
        halves_in++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tokens_out = 0;
    upper_m    = '0;
    c_srdy = 1'b0;
    c_data = '0;
    p_drdy = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_p_srdy",  {31'd0, p_srdy},  32'd0);
    check("rst_partial", {31'd0, partial}, 32'd0);
    check("rst_c_drdy",  {31'd0, c_drdy},  32'd1);
    @(posedge clk);
    #1;

    // Basic reassembly: the word appears one cycle after the lower half is accepted.
    step(1'b1, 4'hA, 1'b1, 1'b0);
    check("basic_partial", {31'd0, partial}, 32'd1);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    check("basic_p_srdy", {31'd0, p_srdy}, 32'd1);
    check("basic_p_data", {24'd0, p_data}, 32'h0000_00A5);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("basic_one_cycle", {31'd0, p_srdy}, 32'd0);

    // Streaming: 8 back-to-back halves with the output always ready.
    for (int i = 1; i <= 8; i++) step(1'b1, i[HW-1:0], 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // Backpressure: 0x12 waits, 0x3 is still taken, and 0x4 stalls.
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    check("bp_stall_cdrdy", {31'd0, c_drdy}, 32'd0);
    check("bp_hold_data",   {24'd0, p_data}, 32'h0000_0012);
    step(1'b1, 4'h4, 1'b1, 1'b0);
    check("bp_no_gap",  {31'd0, p_srdy}, 32'd1);
    check("bp_new_word", {24'd0, p_data}, 32'h0000_0034);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // Reset while an upper half is held: that half is discarded.
    step(1'b1, 4'hF, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check("mid_rst_partial", {31'd0, partial}, 32'd0);
    check("mid_rst_p_srdy",  {31'd0, p_srdy},  32'd0);
    step(1'b1, 4'h1, 1'b1, 1'b0);
    step(1'b1, 4'h2, 1'b1, 1'b0);
    check("mid_rst_word", {24'd0, p_data}, 32'h0000_0012);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // Reset while a finished word is pending: that word is dropped.
    step(1'b1, 4'h6, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b1);
    check("rst_drop_p_srdy", {31'd0, p_srdy}, 32'd0);

    // Randomized traffic with throttling on both sides.
    for (int i = 0; i < 4000; i++) begin
      logic [HW-1:0] d;
      d = HW'($urandom);
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) != 0), 1'b0);
    end
    // Drain whatever is left.
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    check("drained", {31'd0, p_srdy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
